// File: rtl/rf_write_buffer.sv
// Posted-write buffer in front of the register file write port: in-order queue,
// one drain per cycle, youngest-match read bypass. Optional RF_WB_COALESCE_EN merges same-address pushes.
module rf_write_buffer #(
  parameter int W  = 32,
  parameter int L  = 8,
  parameter int D  = 4,
  parameter int LD = 2
) (
  input  logic          clk,
  input  logic          reset_n_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [L-1:0]  wa_i,
  input  logic [W-1:0]  wd_i,
  input  logic          drain_en_i,
  output logic          wen_o,
  output logic [L-1:0]  wa_o,
  output logic [W-1:0]  wd_o,
  input  logic [L-1:0]  ra0_i,
  input  logic [L-1:0]  ra1_i,
  output logic          hit0_o,
  output logic          hit1_o,
  output logic [W-1:0]  bd0_o,
  output logic [W-1:0]  bd1_o,
  output logic [LD:0]   count_o,
  output logic          empty_o,
  output logic          full_o
);

  localparam logic [LD:0] DCNT = (LD+1)'(D);

  logic [L-1:0]  r_addr [D];
  logic [W-1:0]  r_data [D];
  logic [LD-1:0] r_head;
  logic [LD-1:0] r_tail;
  logic [LD:0]   r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_coalesce;
  logic          w_alloc;
  logic [LD-1:0] w_youngest;

  assign w_full     = (r_count == DCNT);
  assign w_empty    = (r_count == '0);
  assign w_youngest = r_tail - 1'b1;

  assign ready_o = reset_n_i & ~w_full;
  assign wen_o   = reset_n_i & ~w_empty & drain_en_i;
  assign w_push  = valid_i & ready_o;
  assign w_pop   = wen_o;

`ifdef RF_WB_COALESCE_EN
  // A lone entry leaving this cycle cannot absorb the new write; allocate instead.
  assign w_coalesce = w_push & ~w_empty & (r_addr[w_youngest] == wa_i) &
                      ~((r_count == (LD+1)'(1)) & w_pop);
`else
  assign w_coalesce = 1'b0;
`endif
  assign w_alloc = w_push & ~w_coalesce;

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      if (w_alloc) r_tail <= r_tail + 1'b1;
      if (w_pop)   r_head <= r_head + 1'b1;
      case ({w_alloc, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: entry storage has no reset; the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_addr[r_tail] <= wa_i;
      r_data[r_tail] <= wd_i;
    end else if (w_coalesce) begin
      r_data[w_youngest] <= wd_i;
    end
  end

  assign wa_o    = w_empty ? '0 : r_addr[r_head];
  assign wd_o    = w_empty ? '0 : r_data[r_head];
  assign count_o = r_count;
  assign empty_o = w_empty;
  assign full_o  = w_full;

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    logic [LD-1:0] idx;
    // NOTE: every output gets a default first so no latch is inferred.
    hit0_o = 1'b0;
    hit1_o = 1'b0;
    bd0_o  = '0;
    bd1_o  = '0;
    idx    = '0;
    for (int k = 0; k < D; k++) begin
      idx = r_head + LD'(k);
      if ((LD+1)'(k) < r_count) begin
        if (r_addr[idx] == ra0_i) begin
          hit0_o = 1'b1;
          bd0_o  = r_data[idx];
        end
        if (r_addr[idx] == ra1_i) begin
          hit1_o = 1'b1;
          bd1_o  = r_data[idx];
        end
      end
    end
  end

endmodule
